// File: rtl/square_motion_ctrl.sv
// Frame-rate motion scheduler for the bouncing test square.
// Detects the first pixel of vertical blanking and, on that tick, updates
// X then Y in two consecutive cycles so the square never tears mid-frame.
module square_motion_ctrl #(
    parameter int unsigned CORDW  = 10,
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned Q_SIZE = 32,
    parameter int unsigned SPEED  = 1
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             run,
    input  logic             step,
    output logic [CORDW-1:0] qx,
    output logic [CORDW-1:0] qy,
    output logic             q_draw,
    output logic             busy,
    output logic             step_done,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned AW = CORDW + 1;
    localparam logic [CORDW-1:0] X_MAX = CORDW'(H_RES - Q_SIZE);
    localparam logic [CORDW-1:0] Y_MAX = CORDW'(V_RES - Q_SIZE);
    localparam logic [AW-1:0]    SPD   = AW'(SPEED);
    localparam logic [AW-1:0]    QSZ   = AW'(Q_SIZE);

    typedef enum logic [1:0] {WAIT, UPD_X, UPD_Y, DONE} state_t;

    state_t           state, state_next;
    logic             tick;
    logic             step_pend;
    logic             from_step;
    logic             dx, dy;
    logic             start_c, upd_x_c, upd_y_c, busy_nxt_c, step_done_nxt_c;
    logic [CORDW:0]   nx_c, ny_c;
    logic             inside_c;

    // One axis move with edge clamp and direction flip; returns {dir, pos}
    function automatic logic [CORDW:0] bounce(input logic [CORDW-1:0] pos,
                                              input logic             dir,
                                              input logic [CORDW-1:0] lim);
        logic [AW-1:0] p;
        logic [AW-1:0] sum;
        p   = AW'(pos);
        sum = p + SPD;
        if (dir) begin
            if (sum > AW'(lim)) bounce = {1'b0, lim};
            else                bounce = {1'b1, sum[CORDW-1:0]};
        end else begin
            if (p < SPD)        bounce = {1'b1, {CORDW{1'b0}}};
            else                bounce = {1'b0, CORDW'(p - SPD)};
        end
    endfunction

    // Registered frame tick at the first pixel of vertical blanking, plus frame counter
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            tick      <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            tick <= (sy == CORDW'(V_RES)) && (sx == {CORDW{1'b0}});
            if (tick) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // State register
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) state <= WAIT;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            WAIT:    if (tick && (run || step_pend)) state_next = UPD_X;
            UPD_X:   state_next = UPD_Y;
            UPD_Y:   state_next = DONE;
            DONE:    state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // FSM decode: update strobes and next values of the registered flags
    always_comb begin
        start_c         = (state == WAIT) && (state_next == UPD_X);
        upd_x_c         = (state == UPD_X);
        upd_y_c         = (state == UPD_Y);
        busy_nxt_c      = (state_next == UPD_X) || (state_next == UPD_Y);
        step_done_nxt_c = (state_next == DONE) && from_step;
    end

    // Registered status flags, step latch and step-origin flag
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            step_done <= 1'b0;
            step_pend <= 1'b0;
            from_step <= 1'b0;
        end else begin
            busy      <= busy_nxt_c;
            step_done <= step_done_nxt_c;
            step_pend <= step | (step_pend & ~start_c);
            if (start_c) from_step <= step_pend & ~run;
        end
    end

    // Candidate next positions for each axis
    always_comb begin
        nx_c = bounce(qx, dx, X_MAX);
        ny_c = bounce(qy, dy, Y_MAX);
    end

    // Position and direction registers, written only during the update states
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            qx <= '0;
            qy <= '0;
            dx <= 1'b1;
            dy <= 1'b1;
        end else begin
            if (upd_x_c) {dx, qx} <= nx_c;
            if (upd_y_c) {dy, qy} <= ny_c;
        end
    end

    // Square hit test on the current raster position
    always_comb begin
        inside_c = (AW'(sx) >= AW'(qx)) && (AW'(sx) < AW'(qx) + QSZ) &&
                   (AW'(sy) >= AW'(qy)) && (AW'(sy) < AW'(qy) + QSZ);
    end

    // Registered draw flag, one cycle behind the coordinates
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) q_draw <= 1'b0;
        else        q_draw <= inside_c;
    end

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Bench for square_motion_ctrl: short synthetic frames, a reference motion
// model and a scoreboard of per-frame expectations, for SPEED=1 and SPEED=5.
module tb_square_motion_ctrl;

    localparam int CORDW = 10;
    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int QS    = 32;

    logic             clk_pix = 1'b0;
    logic             rst_n;
    logic [CORDW-1:0] sx, sy;
    logic             run, step;
    logic [CORDW-1:0] qx, qy, qx5, qy5;
    logic             q_draw, busy, step_done, q_draw5, busy5, step_done5;
    logic [15:0]      frame_cnt, frame_cnt5;

    square_motion_ctrl #(.CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .Q_SIZE(QS), .SPEED(1)) dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .sx(sx), .sy(sy), .run(run), .step(step),
        .qx(qx), .qy(qy), .q_draw(q_draw), .busy(busy), .step_done(step_done),
        .frame_cnt(frame_cnt));

    square_motion_ctrl #(.CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .Q_SIZE(QS), .SPEED(5)) dut5 (
        .clk_pix(clk_pix), .rst_n(rst_n), .sx(sx), .sy(sy), .run(run), .step(step),
        .qx(qx5), .qy(qy5), .q_draw(q_draw5), .busy(busy5), .step_done(step_done5),
        .frame_cnt(frame_cnt5));

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        int qx, qy, qx5, qy5, fcnt, nbusy, bfirst, nsd;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    int m_qx, m_qy, m_dx, m_dy, n_qx, n_qy, n_dx, n_dy, m_fcnt;
    bit m_pend;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void axis(input int p, input int d, input int s, input int lim,
                                 output int np, output int nd);
        np = p; nd = d;
        if (d == 1) begin
            if (p + s > lim) begin np = lim; nd = 0; end
            else np = p + s;
        end else begin
            if (p < s) begin np = 0; nd = 1; end
            else np = p - s;
        end
    endfunction

    function automatic void model_reset();
        m_qx = 0; m_qy = 0; m_dx = 1; m_dy = 1;
        n_qx = 0; n_qy = 0; n_dx = 1; n_dy = 1;
        m_fcnt = 0; m_pend = 0;
    endfunction

    function automatic int inside_sq(input int x, input int y, input int px, input int py);
        return (x >= px && x < px + QS && y >= py && y < py + QS) ? 1 : 0;
    endfunction

    // One 10-cycle frame: tick pixel on cycle 0, step pulses on cycles s1/s2 (-1 = none)
    task automatic frame(input bit r, input int s1, input int s2);
        int bcnt, b5cnt, sdcnt, sd5cnt, bfirst;
        bit go, fs;
        exp_t e;
        bcnt = 0; b5cnt = 0; sdcnt = 0; sd5cnt = 0; bfirst = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_pix);
            if (busy) begin bcnt++; if (bfirst < 0) bfirst = c; end
            if (busy5) b5cnt++;
            if (step_done) sdcnt++;
            if (step_done5) sd5cnt++;
            if (c == 1) begin
                go = r || m_pend;
                fs = m_pend && !r;
                if (go) m_pend = 0;
                m_fcnt = (m_fcnt + 1) % 65536;
                if (go) begin
                    axis(m_qx, m_dx, 1, H_RES - QS, m_qx, m_dx);
                    axis(m_qy, m_dy, 1, V_RES - QS, m_qy, m_dy);
                    axis(n_qx, n_dx, 5, H_RES - QS, n_qx, n_dx);
                    axis(n_qy, n_dy, 5, V_RES - QS, n_qy, n_dy);
                end
                e.qx = m_qx; e.qy = m_qy; e.qx5 = n_qx; e.qy5 = n_qy; e.fcnt = m_fcnt;
                e.nbusy = go ? 2 : 0; e.bfirst = go ? 2 : -1; e.nsd = fs ? 1 : 0;
                q_exp.push_back(e);
            end
            step = (c == s1) || (c == s2);
            if (step) m_pend = 1;
            run = r;
            sy  = CORDW'(V_RES);
            sx  = CORDW'(c);
        end
        if (q_exp.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = q_exp.pop_front();
            chk("qx", int'(qx), e.qx);
            chk("qy", int'(qy), e.qy);
            chk("qx_s5", int'(qx5), e.qx5);
            chk("qy_s5", int'(qy5), e.qy5);
            chk("frame_cnt", int'(frame_cnt), e.fcnt);
            chk("frame_cnt_s5", int'(frame_cnt5), e.fcnt);
            chk("busy_cycles", bcnt, e.nbusy);
            chk("busy_cycles_s5", b5cnt, e.nbusy);
            chk("busy_start", bfirst, e.bfirst);
            chk("step_done_pulses", sdcnt, e.nsd);
            chk("step_done_pulses_s5", sd5cnt, e.nsd);
        end
    endtask

    // Drive a raster position and check the registered draw flag one cycle later
    task automatic probe(input int x, input int y);
        @(negedge clk_pix);
        step = 1'b0;
        sx = CORDW'(x);
        sy = CORDW'(y);
        @(negedge clk_pix);
        chk("q_draw", int'(q_draw), inside_sq(x, y, m_qx, m_qy));
        chk("q_draw_s5", int'(q_draw5), inside_sq(x, y, n_qx, n_qy));
    endtask

    task automatic probe_set();
        probe(m_qx, m_qy);
        probe(m_qx + QS, m_qy);
        probe(m_qx + QS - 1, m_qy + QS - 1);
        probe(m_qx + 16, m_qy + QS);
        if (m_qx > 0) probe(m_qx - 1, m_qy + 5);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; sx = '0; sy = '0;
        model_reset();
        repeat (3) @(negedge clk_pix);
        chk("rst_qx", int'(qx), 0);
        chk("rst_qy", int'(qy), 0);
        chk("rst_q_draw", int'(q_draw), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_step_done", int'(step_done), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        rst_n = 1'b1;

        // free run, then pause
        frame(1, -1, -1);
        frame(1, -1, -1);
        chk("free_run_qx_is_2", int'(qx), 2);
        chk("free_run_fcnt_is_2", int'(frame_cnt), 2);
        repeat (3) frame(0, -1, -1);
        chk("pause_qx_held", int'(qx), 2);
        chk("pause_fcnt_is_5", int'(frame_cnt), 5);

        // mid-frame step while paused: serviced at the next tick
        frame(0, 6, -1);
        frame(0, -1, -1);
        // step on the tick cycle: not consumed until the following tick
        frame(0, 1, -1);
        frame(0, -1, -1);
        // step on the cycle before the tick is picked up by that tick
        frame(0, 0, -1);
        // two steps in one frame merge into one update
        frame(0, 4, 7);
        frame(0, -1, -1);
        frame(0, -1, -1);
        // step while running: absorbed with no extra motion or step_done
        frame(1, 5, -1);
        frame(1, -1, -1);
        frame(0, -1, -1);

        probe_set();

        // long free run through right/bottom bounces and left/top clamps
        repeat (1250) frame(1, -1, -1);
        probe_set();

        // async reset while in UPD_Y
        @(negedge clk_pix);
        run = 1'b1; sx = '0; sy = CORDW'(V_RES);
        @(negedge clk_pix);
        sx = CORDW'(m_qx + 1); sy = CORDW'(m_qy + 1);
        @(negedge clk_pix);
        @(negedge clk_pix);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_q_draw", int'(q_draw), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_qx", int'(qx), 0);
        chk("async_rst_qy", int'(qy), 0);
        chk("async_rst_qx_s5", int'(qx5), 0);
        chk("async_rst_q_draw", int'(q_draw), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_frame_cnt", int'(frame_cnt), 0);
        @(negedge clk_pix);
        rst_n = 1'b1;
        model_reset();
        frame(1, -1, -1);
        chk("after_rst_qx_is_1", int'(qx), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
